// File: rtl/mem_req_arbiter.sv
// Single-port RAM arbiter: serializes fetch and data requests, data first.
// Optional out-of-range address checking: define ARB_ADDR_CHECK_EN.
module mem_req_arbiter #(
   parameter int DATA_W  = 32,
   parameter int DEPTH_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               imem_ren,
   input  logic [31:0]        imem_addr,
   output logic [DATA_W-1:0]  imemload,
   output logic               i_ready,
   input  logic               dmem_ren,
   input  logic               dmem_wen,
   input  logic [31:0]        dmem_addr,
   input  logic [DATA_W-1:0]  dmem_store,
   output logic [DATA_W-1:0]  dmemload,
   output logic               d_ready,
   output logic [DEPTH_W-1:0] ram_addr,
   output logic               ram_wen,
   output logic [DATA_W-1:0]  ram_din,
   input  logic [DATA_W-1:0]  ram_dout,
   output logic               busy,
   output logic               addr_err
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      DONE
   } state_e;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_e;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                store_q, store_d;
   logic                err_q, err_d;
   logic [DEPTH_W-1:0]  ram_addr_q, ram_addr_d;
   logic                ram_wen_q, ram_wen_d;
   logic [DATA_W-1:0]   ram_din_q, ram_din_d;
   logic [DATA_W-1:0]   imemload_q, imemload_d;
   logic [DATA_W-1:0]   dmemload_q, dmemload_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                addr_err_q, addr_err_d;

   logic                d_req;
   logic                i_oob;
   logic                d_oob;
   logic [DATA_W-1:0]   rdata;

   assign d_req = dmem_wen | dmem_ren;

`ifdef ARB_ADDR_CHECK_EN
   assign i_oob = |imem_addr[31:DEPTH_W+2];
   assign d_oob = |dmem_addr[31:DEPTH_W+2];
`else
   // Upper bits dropped on purpose: addresses wrap around the RAM.
   assign i_oob = 1'b0;
   assign d_oob = 1'b0;
`endif

   logic unused_addr_bits;
   assign unused_addr_bits = ^{imem_addr[31:DEPTH_W+2], imem_addr[1:0],
                               dmem_addr[31:DEPTH_W+2], dmem_addr[1:0]};

   // A flagged access returns zero rather than whatever the wrapped word holds.
   assign rdata = err_q ? '0 : ram_dout;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      store_d    = store_q;
      err_d      = err_q;
      ram_addr_d = ram_addr_q;
      ram_wen_d  = ram_wen_q;
      ram_din_d  = ram_din_q;
      imemload_d = imemload_q;
      dmemload_d = dmemload_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
      addr_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (d_req) begin
               owner_d    = OWN_D;
               store_d    = dmem_wen;
               err_d      = d_oob;
               ram_addr_d = dmem_addr[DEPTH_W+1:2];
               ram_wen_d  = dmem_wen & ~d_oob;
               ram_din_d  = dmem_store;
               state_d    = ISSUE;
            end else if (imem_ren) begin
               owner_d    = OWN_I;
               store_d    = 1'b0;
               err_d      = i_oob;
               ram_addr_d = imem_addr[DEPTH_W+1:2];
               ram_wen_d  = 1'b0;
               ram_din_d  = dmem_store;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            ram_wen_d = 1'b0;
            state_d   = CAPTURE;
         end
         CAPTURE: begin
            if (owner_q == OWN_I) begin
               imemload_d = rdata;
               i_ready_d  = 1'b1;
            end else begin
               if (!store_q) begin
                  dmemload_d = rdata;
               end
               d_ready_d = 1'b1;
            end
            addr_err_d = err_q;
            state_d    = DONE;
         end
         DONE: begin
            // Gives the requester a cycle to retire before the next sample.
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_I;
         store_q    <= 1'b0;
         err_q      <= 1'b0;
         ram_addr_q <= '0;
         ram_wen_q  <= 1'b0;
         ram_din_q  <= '0;
         imemload_q <= '0;
         dmemload_q <= '0;
         i_ready_q  <= 1'b0;
         d_ready_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         store_q    <= store_d;
         err_q      <= err_d;
         ram_addr_q <= ram_addr_d;
         ram_wen_q  <= ram_wen_d;
         ram_din_q  <= ram_din_d;
         imemload_q <= imemload_d;
         dmemload_q <= dmemload_d;
         i_ready_q  <= i_ready_d;
         d_ready_q  <= d_ready_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_wen  = ram_wen_q;
   assign ram_din  = ram_din_q;
   assign imemload = imemload_q;
   assign dmemload = dmemload_q;
   assign i_ready  = i_ready_q;
   assign d_ready  = d_ready_q;
   assign busy     = (state_q != IDLE);
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a synchronous read-first RAM model.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ren = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [31:0] imemload;
   logic        i_ready;
   logic        dmem_ren = 1'b0;
   logic        dmem_wen = 1'b0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_store = '0;
   logic [31:0] dmemload;
   logic        d_ready;
   logic [11:0] ram_addr;
   logic        ram_wen;
   logic [31:0] ram_din;
   logic [31:0] ram_dout = '0;
   logic        busy;
   logic        addr_err;

   logic [31:0] mem [0:4095];

   int total = 0;
   int bad   = 0;

   mem_req_arbiter #(.DATA_W(32), .DEPTH_W(12)) dut (
      .clk(clk), .rst(rst),
      .imem_ren(imem_ren), .imem_addr(imem_addr),
      .imemload(imemload), .i_ready(i_ready),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
      .dmem_addr(dmem_addr), .dmem_store(dmem_store),
      .dmemload(dmemload), .d_ready(d_ready),
      .ram_addr(ram_addr), .ram_wen(ram_wen),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (!rst && i_ready && d_ready) begin
         total++;
         bad++;
         $display("FAIL both_ready i=%b d=%b required not both", i_ready, d_ready);
      end
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({ram_addr, ram_wen, ram_din, imemload, dmemload,
           i_ready, d_ready, busy, addr_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs ram_addr=%h wen=%b din=%h il=%h dl=%h ir=%b dr=%b busy=%b err=%b required all 0",
                  ram_addr, ram_wen, ram_din, imemload, dmemload, i_ready, d_ready, busy, addr_err);
      end
      @(negedge clk);
      rst = 1'b0;
      edge1();
      total++;
      if ({busy, i_ready, d_ready} !== 3'b000) begin
         bad++;
         $display("FAIL reset_idle busy/ir/dr=%b required 000", {busy, i_ready, d_ready});
      end
   endtask

   task automatic test_fetch();
      @(negedge clk);
      imem_ren  = 1'b1;
      imem_addr = 32'h0000_0008;
      edge1();
      total++;
      if ({ram_addr, ram_wen, busy} !== {12'd2, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL fetch_issue ram_addr=%0d wen=%b busy=%b required 2 0 1", ram_addr, ram_wen, busy);
      end
      edge1();
      total++;
      if (i_ready !== 1'b0) begin
         bad++;
         $display("FAIL fetch_early_ready i_ready=%b required 0", i_ready);
      end
      edge1();
      total++;
      if ({i_ready, d_ready, imemload} !== {1'b1, 1'b0, 32'h0050_0093}) begin
         bad++;
         $display("FAIL fetch_data ir=%b dr=%b imemload=%h required 1 0 00500093", i_ready, d_ready, imemload);
      end
      imem_ren = 1'b0;
      edge1();
      total++;
      if ({i_ready, busy} !== 2'b00) begin
         bad++;
         $display("FAIL fetch_done ir=%b busy=%b required 0 0", i_ready, busy);
      end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      dmem_wen   = 1'b1;
      dmem_addr  = 32'h0000_0040;
      dmem_store = 32'hDEAD_BEEF;
      edge1();
      total++;
      if ({ram_wen, ram_addr, ram_din} !== {1'b1, 12'd16, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL store_issue wen=%b addr=%0d din=%h required 1 16 deadbeef", ram_wen, ram_addr, ram_din);
      end
      edge1();
      total++;
      if ({ram_wen, mem[16]} !== {1'b0, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL store_write wen=%b mem16=%h required 0 deadbeef", ram_wen, mem[16]);
      end
      edge1();
      total++;
      if ({d_ready, i_ready, dmemload} !== {1'b1, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL store_ready dr=%b ir=%b dmemload=%h required 1 0 0", d_ready, i_ready, dmemload);
      end
      dmem_wen = 1'b0;
      edge1();
      total++;
      if ({d_ready, busy} !== 2'b00) begin
         bad++;
         $display("FAIL store_done dr=%b busy=%b required 0 0", d_ready, busy);
      end
      @(negedge clk);
      dmem_ren = 1'b1;
      repeat (3) edge1();
      total++;
      if ({d_ready, dmemload} !== {1'b1, 32'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL load_data dr=%b dmemload=%h required 1 deadbeef", d_ready, dmemload);
      end
      dmem_ren = 1'b0;
      edge1();
   endtask

   task automatic test_contention();
      @(negedge clk);
      imem_ren  = 1'b1;
      imem_addr = 32'h0000_0008;
      dmem_ren  = 1'b1;
      dmem_addr = 32'h0000_0040;
      edge1();
      total++;
      if ({ram_addr, busy} !== {12'd16, 1'b1}) begin
         bad++;
         $display("FAIL cont_d_first ram_addr=%0d busy=%b required 16 1", ram_addr, busy);
      end
      edge1();
      edge1();
      total++;
      if ({d_ready, i_ready, busy} !== 3'b101) begin
         bad++;
         $display("FAIL cont_d_ready dr/ir/busy=%b required 101", {d_ready, i_ready, busy});
      end
      dmem_ren = 1'b0;
      edge1();
      edge1();
      total++;
      if ({ram_addr, busy, ram_wen} !== {12'd2, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL cont_i_issue ram_addr=%0d busy=%b wen=%b required 2 1 0", ram_addr, busy, ram_wen);
      end
      edge1();
      edge1();
      total++;
      if ({i_ready, d_ready, imemload} !== {1'b1, 1'b0, 32'h0050_0093}) begin
         bad++;
         $display("FAIL cont_i_ready ir=%b dr=%b il=%h required 1 0 00500093", i_ready, d_ready, imemload);
      end
      imem_ren = 1'b0;
      edge1();
   endtask

   task automatic test_early_drop();
      @(negedge clk);
      imem_ren  = 1'b1;
      imem_addr = 32'h0000_000E;
      edge1();
      imem_ren = 1'b0;
      imem_addr = 32'h0000_0000;
      edge1();
      edge1();
      total++;
      if ({i_ready, imemload} !== {1'b1, 32'hA5A5_0003}) begin
         bad++;
         $display("FAIL drop_ready ir=%b il=%h required 1 a5a50003", i_ready, imemload);
      end
      edge1();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      dmem_wen   = 1'b1;
      dmem_addr  = 32'h0000_0044;
      dmem_store = 32'h1234_5678;
      edge1();
      edge1();
      total++;
      if ({busy, ram_wen} !== 2'b10) begin
         bad++;
         $display("FAIL mid_capture busy=%b wen=%b required 1 0", busy, ram_wen);
      end
      rst = 1'b1;
      dmem_wen = 1'b0;
      #1;
      total++;
      if ({ram_addr, ram_wen, ram_din, imemload, dmemload,
           i_ready, d_ready, busy, addr_err} !== '0) begin
         bad++;
         $display("FAIL mid_reset addr=%h wen=%b din=%h il=%h dl=%h ir=%b dr=%b busy=%b required all 0",
                  ram_addr, ram_wen, ram_din, imemload, dmemload, i_ready, d_ready, busy);
      end
      edge1();
      @(negedge clk);
      rst = 1'b0;
      edge1();
      edge1();
      total++;
      if ({i_ready, d_ready, busy} !== 3'b000) begin
         bad++;
         $display("FAIL mid_no_ready ir/dr/busy=%b required 000", {i_ready, d_ready, busy});
      end
      @(negedge clk);
      dmem_wen   = 1'b1;
      dmem_addr  = 32'h0000_0048;
      dmem_store = 32'h0000_0055;
      edge1();
      total++;
      if (ram_wen !== 1'b1) begin
         bad++;
         $display("FAIL async_pre wen=%b required 1", ram_wen);
      end
      rst = 1'b1;
      dmem_wen = 1'b0;
      #1;
      total++;
      if (ram_wen !== 1'b0) begin
         bad++;
         $display("FAIL async_wen_drop wen=%b required 0", ram_wen);
      end
      edge1();
      total++;
      if (mem[18] !== 32'h0) begin
         bad++;
         $display("FAIL async_no_write mem18=%h required 0", mem[18]);
      end
      @(negedge clk);
      rst = 1'b0;
      edge1();
   endtask

   task automatic test_addr_range();
      @(negedge clk);
      dmem_wen   = 1'b1;
      dmem_addr  = 32'h0001_0000;
      dmem_store = 32'hCAFE_F00D;
      edge1();
`ifdef ARB_ADDR_CHECK_EN
      total++;
      if ({ram_wen, ram_addr} !== {1'b0, 12'd0}) begin
         bad++;
         $display("FAIL oob_wen wen=%b addr=%0d required 0 0", ram_wen, ram_addr);
      end
      edge1();
      total++;
      if (mem[0] !== 32'h1111_1111) begin
         bad++;
         $display("FAIL oob_mem mem0=%h required 11111111", mem[0]);
      end
      edge1();
      total++;
      if ({d_ready, addr_err} !== 2'b11) begin
         bad++;
         $display("FAIL oob_err dr=%b err=%b required 1 1", d_ready, addr_err);
      end
`else
      total++;
      if ({ram_wen, ram_addr} !== {1'b1, 12'd0}) begin
         bad++;
         $display("FAIL wrap_wen wen=%b addr=%0d required 1 0", ram_wen, ram_addr);
      end
      edge1();
      total++;
      if (mem[0] !== 32'hCAFE_F00D) begin
         bad++;
         $display("FAIL wrap_mem mem0=%h required cafef00d", mem[0]);
      end
      edge1();
      total++;
      if ({d_ready, addr_err} !== 2'b10) begin
         bad++;
         $display("FAIL wrap_err dr=%b err=%b required 1 0", d_ready, addr_err);
      end
`endif
      dmem_wen = 1'b0;
      edge1();
      @(negedge clk);
      dmem_ren  = 1'b1;
      dmem_addr = 32'h0001_0004;
      repeat (3) edge1();
      total++;
`ifdef ARB_ADDR_CHECK_EN
      if ({d_ready, addr_err, dmemload} !== {2'b11, 32'h0}) begin
         bad++;
         $display("FAIL oob_load dr=%b err=%b dl=%h required 1 1 0", d_ready, addr_err, dmemload);
      end
`else
      if ({d_ready, addr_err, dmemload} !== {2'b10, 32'h2222_2222}) begin
         bad++;
         $display("FAIL wrap_load dr=%b err=%b dl=%h required 1 0 22222222", d_ready, addr_err, dmemload);
      end
`endif
      dmem_ren = 1'b0;
      edge1();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h0050_0093;
      mem[3] = 32'hA5A5_0003;
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_early_drop();
      test_reset_mid();
      test_addr_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
